mfp_uart_rx: RTL and testbench
==============================

Name: mfp_uart_rx

Overview:
- Serial receive front end between the board UART pin (UART_TXD_IN at top level) and the mfp_sys UART_RX consumer.
- Synchronises the asynchronous RX line, deserialises 8N1 frames, and buffers received bytes in a first-word-fall-through FIFO.
- An AHB-side register wrapper pops the FIFO and reads status.
- Error conditions are sticky until the wrapper clears them.

Parameters:
- CLKS_PER_BIT, 434: HCLK cycles per bit (50 MHz / 115200). Legal range is 8 or more. The bench uses 16.
- FIFO_DEPTH_LOG2, 4: FIFO holds 2^FIFO_DEPTH_LOG2 bytes (16 by default).

Ports:
- HCLK  input  1  system clock; all logic is on its rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- UART_RX  input  1  raw serial line; idles high; asynchronous to HCLK.
- rd_en  input  1  pops the FIFO head; ignored when the FIFO is empty.
- clr_err  input  1  clears the sticky overrun and frame_err flags.
- rd_data  output  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_count  output  FIFO_DEPTH_LOG2+1  number of bytes held, 0..2^FIFO_DEPTH_LOG2.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled as 0.

Behaviour:
- Reset: asynchronous, active-low on HRESETn. One clock (HCLK); reset is asynchronous and active-low.
  - Synchroniser flops reset to 1.
  - FSM goes to IDLE; bit counter and baud counter go to 0.
  - FIFO pointers and count go to 0.
  - Output reset values: rx_valid=0, rx_count=0, rd_data=0, overrun=0, frame_err=0.
- Synchroniser: 2 flops. The FSM sees only the second-flop output rxs. Input-to-FSM latency is 2 cycles.
- Baud counter: runs 0..CLKS_PER_BIT-1 and restarts at 0 on every state entry.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rxs=0 -> START, counter cleared.
  - START: at count CLKS_PER_BIT/2-1 (integer division), sample rxs.
    - rxs=0 -> DATA with bit index 0.
    - rxs=1 -> treat as glitch, return to IDLE; nothing is recorded.
  - DATA: sample at every count CLKS_PER_BIT-1 (mid-bit). Shift LSB first into an 8-bit register. After bit index 7 -> STOP.
  - STOP: sample at count CLKS_PER_BIT-1.
    - rxs=1 -> push the byte and go to IDLE.
    - rxs=0 -> set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. This stops a held-low line from producing repeated frames.
- Push: one-cycle strobe in the STOP-sample cycle.
  - FIFO full and no pop in the same cycle: byte is dropped and overrun is set.
  - FIFO full with a pop in the same cycle: push succeeds, no overrun, and rx_count stays at full.
- FIFO behaviour:
  - FWFT: rd_data shows the head combinationally from storage on the cycle after the push edge.
  - rd_en with rx_valid=1 advances the head on the clock edge.
  - rd_en with the FIFO empty has no effect on pointers or count.
- Pointers: FIFO_DEPTH_LOG2 bits and wrap naturally. Full/empty are derived from rx_count.
- rx_count: +1 on push-only, -1 on pop-only, unchanged on push+pop or on neither.
- Push+pop on an empty FIFO: the pop is ignored, the push lands, and count becomes 1.
- Sticky flags: clr_err clears both flags. A set event in the same cycle as clr_err wins, so the flag ends at 1.
- Reset mid-frame: the partial byte is lost. After release, the FSM restarts in IDLE and waits for the next falling edge.
- Frame timing: byte visible on rx_valid about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start-bit falling edge at the pin.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH_LOG2=4):
1. Single frame 0xA5 at 16 cycles/bit, rd_en held 0 -> rx_valid=1, rd_data=0xA5, rx_count=1, overrun=0, frame_err=0. Then pulse rd_en once -> rx_valid=0, rx_count=0.
2. 6-cycle low glitch on idle line -> no state change past START, rx_count stays 0, no flags set.
3. Frame 0x3C with stop bit forced 0, line then held low 100 cycles before returning high -> frame_err=1, rx_count=0, and no second frame decoded during the low period. Then pulse clr_err -> frame_err=0.
4. 17 back-to-back frames 0x00..0x10 with no reads -> rx_count=16, overrun=1. Drain by reading -> 0x00..0x0F in order, and 0x10 is absent.
5. FIFO full (16 bytes) with rd_en asserted exactly in the STOP-sample cycle of a 17th frame 0x77 -> overrun=0, rx_count=16, and 0x77 is the last byte read out.
6. Assert HRESETn=0 for 3 cycles during bit 4 of frame 0x81, then send 0x42 -> only 0x42 is received, and rx_count=1.

Source files
------------

// File: rtl/mfp_uart_rx.sv
// mfp_uart_rx: 8N1 serial receiver with 2-flop synchroniser, FWFT byte FIFO and sticky error flags
module mfp_uart_rx #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       UART_RX,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [7:0]                 rd_data,
    output logic                       rx_valid,
    output logic [FIFO_DEPTH_LOG2:0]   rx_count,
    output logic                       overrun,
    output logic                       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH = (FIFO_DEPTH_LOG2 + 1)'(1 << FIFO_DEPTH_LOG2);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t state, next;
    logic rx_meta, rxs;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic tick, shift, push, ferr_set, pop, wr, ovr_set, full;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [7:0] mem [2**FIFO_DEPTH_LOG2];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = rxs ? IDLE : START;
            START:   if (cnt == HALF) next = rxs ? IDLE : DATA;
            DATA:    if (tick && bit_idx == 3'd7) next = STOP;
            STOP:    if (tick) next = rxs ? IDLE : BREAK;
            BREAK:   next = rxs ? IDLE : BREAK;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        tick     = cnt == LAST;
        shift    = state == DATA && tick;
        push     = state == STOP && tick && rxs;
        ferr_set = state == STOP && tick && !rxs;
        full     = rx_count == DEPTH;
        pop      = rd_en && rx_valid;
        wr       = push && (!full || pop);
        ovr_set  = push && full && !pop;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= UART_RX;
            rxs     <= rx_meta;
            cnt     <= (next != state || tick) ? '0 : cnt + 1'b1;
            bit_idx <= (state == START) ? 3'd0 : shift ? bit_idx + 3'd1 : bit_idx;
            if (shift) shreg <= {rxs, shreg[7:1]};
        end
    end

    // storage needs no reset; rd_data is masked while the FIFO is empty
    always_ff @(posedge HCLK) begin
        if (wr) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_count  <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            rx_count  <= (wr && !pop) ? rx_count + 1'b1 : (pop && !wr) ? rx_count - 1'b1 : rx_count;
            overrun   <= ovr_set | (overrun & ~clr_err);
            frame_err <= ferr_set | (frame_err & ~clr_err);
        end
    end

    assign rx_valid = |rx_count;
    assign rd_data  = rx_valid ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_mfp_uart_rx.sv
// tb_mfp_uart_rx: vector table, directed corner cases and random frames against a queue model
module tb_mfp_uart_rx;
    localparam int CPB = 16;
    localparam int FRAME = 10 * CPB;
    localparam int SAMPLE = 154;
    logic HCLK = 1'b0;
    logic HRESETn, UART_RX, rd_en, clr_err;
    logic [7:0] rd_data;
    logic rx_valid, overrun, frame_err;
    logic [4:0] rx_count;
    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];
    bit m_ovr, m_ferr;

    typedef struct {
        logic [7:0] d;
        bit         stop;
        bit         exp_valid;
        logic [7:0] exp_data;
        logic [4:0] exp_count;
        bit         exp_ferr;
    } vec_t;
    vec_t vt[5];

    mfp_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .UART_RX(UART_RX), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(rd_data), .rx_valid(rx_valid), .rx_count(rx_count), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #900000;
        $display("FAIL watchdog expired act=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic check_state(input string name);
        chk({name, ".valid"}, rx_valid, q.size() != 0);
        chk({name, ".count"}, rx_count, q.size());
        chk({name, ".overrun"}, overrun, m_ovr);
        chk({name, ".frame_err"}, frame_err, m_ferr);
        if (q.size() != 0) chk({name, ".data"}, rd_data, q[0]);
    endtask

    // pop_at/clr_at: cycle within the frame to pulse rd_en/clr_err; SAMPLE is the stop-sample cycle
    task automatic frame(input logic [7:0] d, input bit stop, input int pop_at, input int clr_at, input int low_tail);
        for (int c = 0; c < FRAME; c++) begin
            UART_RX = (c < CPB) ? 1'b0 : (c >= 9 * CPB) ? stop : d[c / CPB - 1];
            rd_en = (c == pop_at);
            clr_err = (c == clr_at);
            idle(1);
        end
        rd_en = 1'b0;
        clr_err = 1'b0;
        if (!stop) idle(low_tail);
        UART_RX = 1'b1;
        idle(4);
        if (pop_at >= 0 && q.size() != 0) void'(q.pop_front());
        if (clr_at >= 0) {m_ovr, m_ferr} = 2'b00;
        if (!stop) m_ferr = 1'b1;
        else if (q.size() < 16) q.push_back(d);
        else m_ovr = 1'b1;
    endtask

    task automatic read_one(input string name);
        chk({name, ".rd_valid"}, rx_valid, 1'b1);
        chk({name, ".rd_data"}, rd_data, q[0]);
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
        void'(q.pop_front());
    endtask

    task automatic clear();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        {m_ovr, m_ferr} = 2'b00;
    endtask

    initial begin
        vt[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0};
        vt[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
        vt[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 5'd1, 1'b0};
        vt[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 5'd1, 1'b0};
        vt[4] = '{8'h96, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
        HRESETn = 1'b0;
        UART_RX = 1'b1;
        rd_en = 1'b0;
        clr_err = 1'b0;
        {m_ovr, m_ferr} = 2'b00;
        idle(3);
        chk("reset.valid", rx_valid, 1'b0);
        chk("reset.count", rx_count, 5'd0);
        chk("reset.data", rd_data, 8'h00);
        chk("reset.flags", {overrun, frame_err}, 2'b00);
        HRESETn = 1'b1;
        idle(5);
        check_state("post_reset");

        foreach (vt[i]) begin
            frame(vt[i].d, vt[i].stop, -1, -1, 8);
            chk($sformatf("vec%0d.valid", i), rx_valid, vt[i].exp_valid);
            chk($sformatf("vec%0d.count", i), rx_count, vt[i].exp_count);
            chk($sformatf("vec%0d.ferr", i), frame_err, vt[i].exp_ferr);
            chk($sformatf("vec%0d.ovr", i), overrun, 1'b0);
            if (vt[i].exp_valid) begin
                chk($sformatf("vec%0d.data", i), rd_data, vt[i].exp_data);
                read_one($sformatf("vec%0d", i));
            end
            clear();
            check_state($sformatf("vec%0d.after", i));
        end

        frame(8'hA5, 1'b1, -1, -1, 0);
        chk("t1.data", rd_data, 8'hA5);
        check_state("t1");
        read_one("t1");
        chk("t1.empty", {rx_valid, rx_count}, 6'd0);

        rd_en = 1'b1;
        idle(2);
        rd_en = 1'b0;
        chk("empty_pop.count", rx_count, 5'd0);

        UART_RX = 1'b0;
        idle(6);
        UART_RX = 1'b1;
        idle(30);
        check_state("t2.glitch");

        frame(8'h3C, 1'b0, -1, -1, 100);
        chk("t3.ferr", frame_err, 1'b1);
        chk("t3.count", rx_count, 5'd0);
        check_state("t3");
        clear();
        chk("t3.clr", frame_err, 1'b0);

        for (int i = 0; i < 17; i++) frame(8'(i), 1'b1, -1, -1, 0);
        chk("t4.count", rx_count, 5'd16);
        chk("t4.ovr", overrun, 1'b1);
        check_state("t4");
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4.order%0d", i), rd_data, 8'(i));
            read_one("t4");
        end
        chk("t4.drained", rx_valid, 1'b0);
        clear();

        for (int i = 0; i < 16; i++) frame(8'hB0 + 8'(i), 1'b1, -1, -1, 0);
        frame(8'h77, 1'b1, SAMPLE, -1, 0);
        chk("t5.ovr", overrun, 1'b0);
        chk("t5.count", rx_count, 5'd16);
        check_state("t5");
        while (q.size() > 1) read_one("t5");
        chk("t5.last", rd_data, 8'h77);
        read_one("t5");

        frame(8'h5A, 1'b1, SAMPLE, -1, 0);
        chk("pushpop_empty.count", rx_count, 5'd1);
        check_state("pushpop_empty");
        read_one("pushpop_empty");

        frame(8'hC3, 1'b0, -1, SAMPLE, 0);
        chk("set_wins.ferr", frame_err, 1'b1);
        clear();

        for (int c = 0; c < 5 * CPB + 6; c++) begin
            UART_RX = (c < CPB) ? 1'b0 : (c % CPB == 0 || c >= 8 * CPB) ? 1'b1 : 1'b0;
            if (c >= CPB) UART_RX = logic'((8'h81 >> (c / CPB - 1)) & 8'h01);
            idle(1);
        end
        HRESETn = 1'b0;
        UART_RX = 1'b1;
        idle(3);
        HRESETn = 1'b1;
        q.delete();
        {m_ovr, m_ferr} = 2'b00;
        idle(20);
        check_state("t6.reset");
        frame(8'h42, 1'b1, -1, -1, 0);
        chk("t6.count", rx_count, 5'd1);
        chk("t6.data", rd_data, 8'h42);
        read_one("t6");

        for (int i = 0; i < 40; i++) begin
            frame(8'($urandom), $urandom_range(0, 9) != 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SAMPLE)) : -1,
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, SAMPLE)) : -1,
                  int'($urandom_range(0, 40)));
            check_state($sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(0, q.size())) read_one("rnd");
            if ($urandom_range(0, 7) == 0) clear();
        end
        while (q.size() != 0) read_one("rnd.drain");
        check_state("rnd.end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
